// File: rtl/ft_rx_cmd_parser.sv
// rtl/ft_rx_cmd_parser.sv - frames USB RX bytes into checksummed command packets and replays them as register writes
module ft_rx_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 60000
) (
    input  logic       uclk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       wr_valid_o,
    input  logic       wr_ready_i,
    output logic       frame_ok_o,
    output logic       err_o,
    output logic [7:0] err_cnt_o
);

    // Buffer index width; the buffer is rounded up to a power of two so the
    // index slice always addresses a real entry.
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // Timeout counter only ever needs to hold 0..TIMEOUT-1.
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    base_q, base_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    xor_q, xor_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_ok_q, frame_ok_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [7:0]    buf_q [2**IW];
    logic          buf_we;
    logic          err_evt;
    logic          rx_accept;
    logic          draining;

    assign draining   = (state_q == S_DRAIN);
    assign rx_ready_o = !draining;
    assign rx_accept  = rx_valid_i && rx_ready_o;

    // Write port is only meaningful while draining; zero otherwise so idle/reset look clean.
    assign wr_valid_o = draining;
    assign wr_addr_o  = draining ? (base_q + idx_q) : 8'h00;
    assign wr_data_o  = draining ? buf_q[idx_q[IW-1:0]] : 8'h00;

    assign frame_ok_o = frame_ok_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;

    // Next-state, framing, checksum, timeout and drain sequencing.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        cnt_d      = cnt_q;
        frame_ok_d = 1'b0;
        err_evt    = 1'b0;
        buf_we     = 1'b0;

        case (state_q)
            S_HUNT: begin
                cnt_d = '0;
                if (rx_accept && (rx_byte_i == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end
            S_DRAIN: begin
                cnt_d = '0;
                if (wr_ready_i) begin
                    if (idx_q == len_q - 8'd1) begin
                        idx_d   = 8'd0;
                        state_d = S_HUNT;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: begin
                // Mid-frame states: an accepted byte always beats timeout expiry.
                if (rx_accept) begin
                    cnt_d = '0;
                    case (state_q)
                        S_ADDR: begin
                            base_d  = rx_byte_i;
                            xor_d   = rx_byte_i;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            len_d = rx_byte_i;
                            xor_d = xor_q ^ rx_byte_i;
                            idx_d = 8'd0;
                            if (rx_byte_i > MAX_LEN_B) begin
                                err_evt = 1'b1;
                                state_d = S_HUNT;
                            end else if (rx_byte_i == 8'd0) begin
                                state_d = S_CSUM;
                            end else begin
                                state_d = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            buf_we = 1'b1;
                            xor_d  = xor_q ^ rx_byte_i;
                            idx_d  = idx_q + 8'd1;
                            if (idx_q == len_q - 8'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                        S_CSUM: begin
                            idx_d = 8'd0;
                            if (rx_byte_i == xor_q) begin
                                frame_ok_d = 1'b1;
                                state_d    = (len_q == 8'd0) ? S_HUNT : S_DRAIN;
                            end else begin
                                err_evt = 1'b1;
                                state_d = S_HUNT;
                            end
                        end
                        default: state_d = S_HUNT;
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    err_evt = 1'b1;
                    state_d = S_HUNT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        err_d     = err_evt;
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Control and status registers; reset drops any partial frame silently.
    always_ff @(posedge uclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_HUNT;
            base_q     <= 8'h00;
            len_q      <= 8'h00;
            idx_q      <= 8'h00;
            xor_q      <= 8'h00;
            cnt_q      <= '0;
            frame_ok_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            cnt_q      <= cnt_d;
            frame_ok_q <= frame_ok_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Payload buffer; contents are only read after a full frame rewrote them.
    always_ff @(posedge uclk_i) begin
        if (buf_we) begin
            buf_q[idx_q[IW-1:0]] <= rx_byte_i;
        end
    end

endmodule

// File: tb/tb_ft_rx_cmd_parser.sv
// tb/tb_ft_rx_cmd_parser.sv - self-checking bench for ft_rx_cmd_parser
module tb_ft_rx_cmd_parser;

    localparam int MAXL = 16;
    localparam int TO   = 20;

    logic       uclk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready = 1'b1;
    logic       frame_ok;
    logic       err;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    int exp_ok = 0, exp_err = 0, model_cnt = 0;
    int ok_seen = 0, err_seen = 0, wr_seen = 0;
    int cyc = 0, last_acc = -10, acc_gap = 0;

    ft_rx_cmd_parser #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN  (MAXL),
        .TIMEOUT  (TO)
    ) dut (
        .uclk_i    (uclk),
        .rst_i     (rst),
        .rx_byte_i (rx_byte),
        .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_valid_o(wr_valid),
        .wr_ready_i(wr_ready),
        .frame_ok_o(frame_ok),
        .err_o     (err),
        .err_cnt_o (err_cnt)
    );

    always #5 uclk = ~uclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_err();
        exp_err++;
        if (model_cnt < 255) model_cnt++;
    endtask

    // Frame-level reference: scan a byte list and list the writes/outcomes it must produce.
    task automatic model_frames(input logic [7:0] s[$]);
        int i;
        int n;
        int l;
        logic [7:0] a;
        logic [7:0] x;
        i = 0;
        n = s.size();
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 2 >= n) break;
            a = s[i+1];
            l = int'(s[i+2]);
            if (l > MAXL) begin
                note_err();
                i += 3;
                continue;
            end
            if (i + 3 + l >= n) break;
            x = a ^ s[i+2];
            for (int k = 0; k < l; k++) x ^= s[i+3+k];
            if (x == s[i+3+l]) begin
                exp_ok++;
                for (int k = 0; k < l; k++) exp_q.push_back({8'(int'(a) + k), s[i+3+k]});
            end else begin
                note_err();
            end
            i += 4 + l;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!rx_ready && g < 200) begin
            @(negedge uclk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_byte: rx_ready stuck low, got 0 expected 1");
        end
        @(negedge uclk);
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge uclk);
        while ((wr_valid || exp_q.size() != 0) && g < 200) begin
            @(negedge uclk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: drain incomplete, got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge uclk);
    endtask

    task automatic check_counts(input string name);
        chk({name, "_frame_ok_count"}, ok_seen, exp_ok);
        chk({name, "_err_count"}, err_seen, exp_err);
        chk({name, "_err_cnt_o"}, err_cnt, model_cnt);
        chk({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Compare process: runs every cycle just after the input-drive point.
    task automatic monitor();
        logic        pv;
        logic [15:0] pw;
        logic [15:0] e;
        pv = 1'b0;
        pw = 16'h0;
        forever begin
            @(negedge uclk);
            #2;
            cyc++;
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            chk("rx_ready_vs_drain", rx_ready, !wr_valid);
            if (frame_ok && err) chk("ok_err_exclusive", 1, 0);
            if (frame_ok) ok_seen++;
            if (err) err_seen++;
            if (pv && wr_valid) chk("write_hold_stable", {wr_addr, wr_data}, pw);
            if (wr_valid && wr_ready) begin
                wr_seen++;
                acc_gap  = cyc - last_acc;
                last_acc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected none", {wr_addr, wr_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr_data", {wr_addr, wr_data}, e);
                end
                pv = 1'b0;
            end else begin
                pv = wr_valid;
                pw = {wr_addr, wr_data};
            end
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int w0;
        int e0;
        logic [7:0] x;

        fork
            monitor();
        join_none

        rst = 1'b1;
        repeat (3) @(negedge uclk);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(negedge uclk);

        // 1: good two-byte frame, back-to-back writes
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        w0 = wr_seen;
        model_frames(q);
        chk("t1_model_w0", exp_q[0], 16'h1011);
        chk("t1_model_w1", exp_q[1], 16'h1122);
        send_seq(q);
        wait_idle();
        check_counts("t1");
        chk("t1_writes", wr_seen - w0, 2);
        chk("t1_consecutive", acc_gap, 1);

        // 2: bad checksum
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
        w0 = wr_seen;
        model_frames(q);
        send_seq(q);
        wait_idle();
        check_counts("t2");
        chk("t2_err_cnt_lit", err_cnt, 1);
        chk("t2_writes", wr_seen - w0, 0);

        // 3: noise, then frame with SYNC value inside the payload and address wrap
        q = '{8'h00, 8'h33, 8'hA5, 8'hFE, 8'h02, 8'hAA, 8'hA5, 8'hF3};
        model_frames(q);
        chk("t3_model_w0", exp_q[0], 16'hFEAA);
        chk("t3_model_w1", exp_q[1], 16'hFFA5);
        send_seq(q);
        wait_idle();
        check_counts("t3");

        // 4: LEN over limit, then a zero-length frame
        q = '{8'hA5, 8'h40, 8'h11, 8'hA5, 8'h40, 8'h00, 8'h40};
        w0 = wr_seen;
        e0 = exp_err;
        model_frames(q);
        chk("t4_model_errs", exp_err - e0, 1);
        send_seq(q);
        wait_idle();
        check_counts("t4");
        chk("t4_writes", wr_seen - w0, 0);

        // 4b: LEN exactly MAX_LEN, wrapping base
        q = '{8'hA5, 8'hF8, 8'd16};
        x = 8'hF8 ^ 8'd16;
        for (int i = 0; i < 16; i++) begin
            q.push_back(8'(8'hA0 + i));
            x ^= 8'(8'hA0 + i);
        end
        q.push_back(x);
        w0 = wr_seen;
        model_frames(q);
        chk("t4b_model_w8", exp_q[8], 16'h00A8);
        send_seq(q);
        wait_idle();
        check_counts("t4b");
        chk("t4b_writes", wr_seen - w0, 16);

        // 5: timeout fires exactly once after TO idle cycles
        send_byte(8'hA5);
        send_byte(8'h10);
        for (int i = 1; i < TO; i++) begin
            @(negedge uclk);
            chk("t5_no_early_err", err, 0);
        end
        @(negedge uclk);
        chk("t5_timeout_err", err, 1);
        note_err();
        @(negedge uclk);
        chk("t5_err_one_cycle", err, 0);
        wait_idle();
        check_counts("t5a");

        // 5b: byte arriving on the expiry cycle wins
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        model_frames(q);
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TO - 1) @(negedge uclk);
        send_byte(8'h02);
        chk("t5b_no_err", err, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h21);
        wait_idle();
        check_counts("t5b");

        // 6: back-pressure in DRAIN, then reset mid-drain
        wr_ready = 1'b0;
        q = '{8'hA5, 8'h30, 8'h03, 8'h01, 8'h02, 8'h03, 8'h33};
        model_frames(q);
        send_seq(q);
        for (int g = 0; g < 20 && !wr_valid; g++) @(negedge uclk);
        chk("t6_drain_entered", wr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge uclk);
            chk("t6_hold_rx_ready", rx_ready, 0);
            chk("t6_hold_addr", wr_addr, 8'h30);
            chk("t6_hold_data", wr_data, 8'h01);
        end
        wr_ready = 1'b1;
        @(negedge uclk);
        wr_ready = 1'b0;
        @(negedge uclk);
        chk("t6_second_addr", wr_addr, 8'h31);
        chk("t6_second_data", wr_data, 8'h02);
        rst = 1'b1;
        #1;
        chk("t6_rst_wr_valid", wr_valid, 0);
        chk("t6_rst_rx_ready", rx_ready, 1);
        chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_wr_data", wr_data, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_frame_ok", frame_ok, 0);
        chk("t6_rst_err_cnt", err_cnt, 0);
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(negedge uclk);
        rst = 1'b0;
        wr_ready = 1'b1;
        @(negedge uclk);

        // 7: normal operation after reset
        q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        model_frames(q);
        send_seq(q);
        wait_idle();
        check_counts("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
